// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin arbiter that grants one of four requesters a burst of writes into a FIFO.
// Latency: fifo_wr_en/fifo_din are registered and appear one cycle after each accepted beat.
// Backpressure: req_ready drops on fifo_full, or on fifo_almost_full with a write in flight; the grant is held.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              req_valid,
    input  logic [4*DATA_WIDTH-1:0] req_data,
    output logic [3:0]              req_ready,
    input  logic                    fifo_full,
    input  logic                    fifo_almost_full,
    output logic                    fifo_wr_en,
    output logic [DATA_WIDTH-1:0]   fifo_din,
    output logic [3:0]              grant,
    output logic                    busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(BURST_MAX);

    state_t                  state_q, state_d;
    logic [1:0]              g_q, g_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [1:0]              last_q, last_d;
    logic                    wr_en_d;
    logic [DATA_WIDTH-1:0]   din_d;

    logic                    stall;
    logic                    owner_vld;
    logic                    xfer;
    logic                    pick_vld;
    logic [1:0]              pick_idx;
    logic [1:0]              cand;
    logic [DATA_WIDTH-1:0]   owner_dat;

    // A write already in flight consumes the last free slot, so almost-full counts as full then.
    assign stall     = fifo_full | (fifo_almost_full & fifo_wr_en);
    assign owner_vld = req_valid[g_q];
    assign xfer      = (state_q == BURST) & owner_vld & ~stall;
    assign busy      = (state_q == BURST);
    assign grant     = busy ? (4'b0001 << g_q) : 4'b0000;
    assign req_ready = (busy && !stall) ? (4'b0001 << g_q) : 4'b0000;

    // Round-robin pick: scan last+4 down to last+1 so the nearest requester after last wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        cand     = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_q + 2'(i);
            if (req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Select the current owner's data lane.
    always_comb begin
        owner_dat = '0;
        for (int i = 0; i < 4; i++) begin
            if (g_q == 2'(i)) begin
                owner_dat = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic: arbitration in IDLE, beat counting and release in BURST.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wr_en_d = 1'b0;
        din_d   = fifo_din;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    g_d     = pick_idx;
                    cnt_d   = 4'd0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    wr_en_d = 1'b1;
                    din_d   = owner_dat;
                    cnt_d   = cnt_q + 4'd1;
                    if ((cnt_q + 4'd1) == CNT_MAX) begin
                        state_d = IDLE;
                        last_d  = g_q;
                    end
                end else if (!owner_vld) begin
                    // Owner withdrew: forfeit the rest of the burst. A stall with valid held keeps the grant.
                    state_d = IDLE;
                    last_d  = g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered FIFO write port; last resets to 3 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            g_q        <= 2'd0;
            cnt_q      <= 4'd0;
            last_q     <= 2'd3;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            fifo_wr_en <= wr_en_d;
            fifo_din   <= din_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose: self-checking bench for fifo_wr_arbiter (BURST_MAX=4 instance plus a BURST_MAX=1 instance).
// Latency: writes are matched in order against a queue of expected data.
// Backpressure: a counting FIFO model drives the full/almost-full flags.
module tb_fifo_wr_arbiter;

    localparam int DW  = 8;
    localparam int CAP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [4*DW-1:0] req_data;
    logic [3:0]    req_ready;
    logic          fifo_full;
    logic          fifo_almost_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic [3:0]    grant;
    logic          busy;

    logic [3:0]    v1;
    logic [4*DW-1:0] d1;
    logic [3:0]    ready1;
    logic          f1;
    logic          wr1;
    logic [DW-1:0] din1;
    logic [3:0]    grant1;
    logic          busy1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb[$];
    logic [3:0]    en;
    int            seq[4];
    int            limit[4];
    bit            raw;
    bit            drain;
    int            fcount;

    int            ob_owner[8];
    int            ob_beats[8];
    int            ob_gap[8];
    int            ob_n;
    bit            ob_timeout;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .grant(grant), .busy(busy)
    );

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_data(d1), .req_ready(ready1),
        .fifo_full(f1), .fifo_almost_full(f1), .fifo_wr_en(wr1),
        .fifo_din(din1), .grant(grant1), .busy(busy1)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dval(input int o, input int s);
        logic [1:0] ob;
        logic [5:0] sbits;
        ob    = o[1:0];
        sbits = s[5:0];
        return {ob, sbits};
    endfunction

    function automatic int oh2i(input logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = en[i] && (seq[i] < limit[i]);
            req_data[i*DW +: DW] = raw ? 8'(seq[i] + 1) : dval(i, seq[i]);
        end
    endtask

    task automatic set_flags();
        fifo_full        = (fcount >= CAP);
        fifo_almost_full = (fcount >= CAP - 1);
    endtask

    // One clock: advance FIFO model and sources, then check any write against the scoreboard.
    task automatic cycle();
        logic          wr_pre;
        logic          full_pre;
        logic [3:0]    hs;
        logic [DW-1:0] exp_d;
        wr_pre   = fifo_wr_en;
        full_pre = fifo_full;
        hs       = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (wr_pre) begin
            checks++;
            if (full_pre) begin
                errors++;
                $display("FAIL overflow: fifo_wr_en=1 while fifo_full=1, required no write");
            end
        end
        fcount += int'(wr_pre);
        if (drain) fcount = 0;
        set_flags();
        for (int i = 0; i < 4; i++) if (hs[i]) seq[i]++;
        refresh();
        #1;
        if (fifo_wr_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: write of %h, required no write", fifo_din);
            end else begin
                exp_d = sb.pop_front();
                if (fifo_din !== exp_d) begin
                    errors++;
                    $display("FAIL sb_data: fifo_din=%h, required %h", fifo_din, exp_d);
                end
            end
        end
    endtask

    // Records owner, beat count and preceding idle gap of each burst (no comparisons here).
    task automatic observe(input int nb, input int max_cyc, input bit stop_after);
        bit prev_busy;
        bit done;
        int idle;
        int c;
        ob_n = 0; ob_timeout = 1'b0; done = 1'b0; idle = 0; c = 0;
        prev_busy = busy;
        while (!done && c < max_cyc) begin
            cycle();
            c++;
            if (busy && !prev_busy) begin
                ob_owner[ob_n] = oh2i(grant);
                ob_gap[ob_n]   = idle;
                ob_beats[ob_n] = 0;
                idle = 0;
            end
            if (!busy) idle++;
            if (busy && (|(req_valid & req_ready))) ob_beats[ob_n]++;
            if (!busy && prev_busy) begin
                ob_n++;
                if (ob_n == nb) begin
                    done = 1'b1;
                    if (stop_after) begin
                        en = 4'b0000;
                        refresh();
                    end
                end
            end
            prev_busy = busy;
        end
        ob_timeout = !done;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 4'b0000; raw = 1'b0; drain = 1'b1; fcount = 0;
        for (int i = 0; i < 4; i++) begin seq[i] = 0; limit[i] = 100; end
        sb.delete();
        v1 = 4'b0000;
        set_flags();
        refresh();
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int busy_seen;
        rst = 1'b0;
        en = 4'b1111;
        refresh();
        cycle();
        cycle();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: %b, required 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: %b, required 0000", req_ready); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: %b, required 0", fifo_wr_en); end
        checks++; if (fifo_din !== 8'h00) begin errors++; $display("FAIL rst_din: %h, required 00", fifo_din); end
        en = 4'b0000;
        refresh();
        rst = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (busy) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL idle_no_req: busy cycles=%0d, required 0", busy_seen); end
        en = 4'b0001;
        refresh();
        cycle();
        checks++; if (busy !== 1'b1 || grant !== 4'b0001) begin errors++; $display("FAIL first_arb: busy=%b grant=%b, required 1 0001", busy, grant); end
        en = 4'b0000;
        refresh();
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_no_xfer: busy=%b, required 0", busy); end
        cycle();
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL no_beat_written: wr_en=%b, required 0", fifo_wr_en); end
    endtask

    task automatic test_rotation();
        do_reset();
        en = 4'b1111;
        refresh();
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 4; k++) sb.push_back(dval(b % 4, (b / 4) * 4 + k));
        observe(5, 80, 1'b1);
        checks++; if (ob_timeout) begin errors++; $display("FAIL rot_timeout: %0d bursts seen, required 5", ob_n); end
        for (int b = 0; b < ob_n; b++) begin
            checks++; if (ob_owner[b] != b % 4) begin errors++; $display("FAIL rot_owner[%0d]: %0d, required %0d", b, ob_owner[b], b % 4); end
            checks++; if (ob_beats[b] != 4) begin errors++; $display("FAIL rot_beats[%0d]: %0d, required 4", b, ob_beats[b]); end
            if (b > 0) begin
                checks++; if (ob_gap[b] != 1) begin errors++; $display("FAIL rot_gap[%0d]: %0d, required 1", b, ob_gap[b]); end
            end
        end
        cycle();
        cycle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rot_missing: %0d writes outstanding, required 0", sb.size()); end
    endtask

    task automatic test_single_req();
        do_reset();
        raw = 1'b1;
        en = 4'b0100;
        limit[2] = 6;
        refresh();
        for (int k = 1; k <= 6; k++) sb.push_back(8'(k));
        observe(2, 60, 1'b0);
        checks++; if (ob_timeout) begin errors++; $display("FAIL single_timeout: %0d bursts seen, required 2", ob_n); end
        checks++; if (ob_owner[0] != 2 || ob_owner[1] != 2) begin errors++; $display("FAIL single_owner: %0d %0d, required 2 2", ob_owner[0], ob_owner[1]); end
        checks++; if (ob_beats[0] != 4 || ob_beats[1] != 2) begin errors++; $display("FAIL single_beats: %0d %0d, required 4 2", ob_beats[0], ob_beats[1]); end
        checks++; if (ob_gap[1] != 1) begin errors++; $display("FAIL single_gap: %0d, required 1", ob_gap[1]); end
        cycle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL single_missing: %0d outstanding, required 0", sb.size()); end
    endtask

    task automatic test_drop();
        do_reset();
        en = 4'b1010;
        limit[1] = 2;
        limit[3] = 4;
        refresh();
        sb.push_back(dval(1, 0)); sb.push_back(dval(1, 1));
        for (int k = 0; k < 4; k++) sb.push_back(dval(3, k));
        observe(2, 60, 1'b1);
        checks++; if (ob_timeout) begin errors++; $display("FAIL drop_timeout: %0d bursts seen, required 2", ob_n); end
        checks++; if (ob_owner[0] != 1 || ob_owner[1] != 3) begin errors++; $display("FAIL drop_owner: %0d %0d, required 1 3", ob_owner[0], ob_owner[1]); end
        checks++; if (ob_beats[0] != 2 || ob_beats[1] != 4) begin errors++; $display("FAIL drop_beats: %0d %0d, required 2 4", ob_beats[0], ob_beats[1]); end
        checks++; if (ob_gap[1] != 1) begin errors++; $display("FAIL drop_gap: %0d, required 1", ob_gap[1]); end
        cycle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL drop_missing: %0d outstanding, required 0", sb.size()); end
    endtask

    task automatic test_stall();
        int c;
        do_reset();
        drain = 1'b0;
        fcount = 5;
        set_flags();
        en = 4'b0001;
        limit[0] = 4;
        refresh();
        for (int k = 0; k < 4; k++) sb.push_back(dval(0, k));
        c = 0;
        while (!fifo_almost_full && c < 20) begin cycle(); c++; end
        checks++; if (!fifo_almost_full) begin errors++; $display("FAIL stall_timeout: almost_full never rose, required rise"); end
        checks++; if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b1) begin errors++; $display("FAIL stall_af: ready=%b wr_en=%b, required 0000 1", req_ready, fifo_wr_en); end
        cycle();
        checks++; if (fifo_full !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL stall_full: full=%b ready=%b, required 1 0000", fifo_full, req_ready); end
        for (int i = 0; i < 3; i++) cycle();
        checks++; if (busy !== 1'b1 || grant !== 4'b0001 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_hold: busy=%b grant=%b wr_en=%b, required 1 0001 0", busy, grant, fifo_wr_en); end
        fcount = 0;
        set_flags();
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_resume: ready=%b, required 0001", req_ready); end
        c = 0;
        while (busy && c < 10) begin cycle(); c++; end
        cycle();
        checks++; if (busy !== 1'b0 || sb.size() != 0) begin errors++; $display("FAIL stall_done: busy=%b outstanding=%0d, required 0 0", busy, sb.size()); end
    endtask

    task automatic test_mid_reset();
        int c;
        do_reset();
        en = 4'b0100;
        refresh();
        sb.push_back(dval(2, 0)); sb.push_back(dval(2, 1));
        c = 0;
        while (seq[2] < 2 && c < 20) begin cycle(); c++; end
        checks++; if (seq[2] < 2) begin errors++; $display("FAIL midrst_timeout: %0d beats, required 2", seq[2]); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL midrst_grant: grant=%b busy=%b, required 0000 0", grant, busy); end
        checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || fifo_din !== 8'h00) begin errors++; $display("FAIL midrst_out: wr_en=%b ready=%b din=%h, required 0 0000 00", fifo_wr_en, req_ready, fifo_din); end
        sb.delete();
        cycle();
        for (int i = 0; i < 4; i++) seq[i] = 0;
        en = 4'b1111;
        refresh();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back(dval(0, k));
        observe(1, 30, 1'b1);
        checks++; if (ob_timeout || ob_owner[0] != 0 || ob_beats[0] != 4) begin errors++; $display("FAIL midrst_first: timeout=%0d owner=%0d beats=%0d, required 0 0 4", ob_timeout, ob_owner[0], ob_beats[0]); end
        cycle();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL midrst_missing: %0d outstanding, required 0", sb.size()); end
    endtask

    task automatic test_burst_max1();
        int owners[5];
        int lens[5];
        int nb;
        int run;
        int c;
        bit prev;
        do_reset();
        for (int i = 0; i < 4; i++) d1[i*DW +: DW] = 8'(8'hA0 + i);
        v1 = 4'b1111;
        nb = 0; run = 0; c = 0; prev = 1'b0;
        while (nb < 5 && c < 40) begin
            @(posedge clk);
            #2;
            c++;
            if (busy1 && !prev) begin owners[nb] = oh2i(grant1); run = 0; end
            if (busy1) run++;
            if (!busy1 && prev) begin
                lens[nb] = run;
                checks++;
                if (wr1 !== 1'b1 || din1 !== 8'(8'hA0 + owners[nb])) begin
                    errors++;
                    $display("FAIL bm1_write[%0d]: wr=%b din=%h, required 1 %h", nb, wr1, din1, 8'(8'hA0 + owners[nb]));
                end
                nb++;
            end
            prev = busy1;
        end
        v1 = 4'b0000;
        checks++; if (nb != 5) begin errors++; $display("FAIL bm1_timeout: %0d grants, required 5", nb); end
        for (int b = 0; b < nb; b++) begin
            checks++; if (owners[b] != b % 4 || lens[b] != 1) begin errors++; $display("FAIL bm1_grant[%0d]: owner=%0d len=%0d, required %0d 1", b, owners[b], lens[b], b % 4); end
        end
    endtask

    initial begin
        rst = 1'b0;
        en = 4'b0000; raw = 1'b0; drain = 1'b1; fcount = 0;
        for (int i = 0; i < 4; i++) begin seq[i] = 0; limit[i] = 100; end
        v1 = 4'b0000; d1 = '0; f1 = 1'b0;
        set_flags();
        refresh();
        test_reset();
        test_rotation();
        test_single_req();
        test_drop();
        test_stall();
        test_mid_reset();
        test_burst_max1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
